// File: rtl/l3_arb_pkg.sv
// Shared definitions for the L3 ring arbiter: FSM encoding, default sizing constants
// and the index-width helper used by the arbiter and its round-robin picker.
package l3_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam longint unsigned L3_SIZE_DEF = 64'd4194304;
  localparam int unsigned     TIMEOUT_DEF = 1024;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l3_ring_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// last_grant, wrapping; last_grant itself is considered last.
module rr_pick
  import l3_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  always_comb begin : pick
    logic [IDX_W-1:0] cand;
    grant   = last_grant;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
  end

endmodule

// File: rtl/l3_ring_arbiter.sv
// Round-robin arbiter sharing one L3 memory between NUM_REQ ring ports, one
// transaction in flight, with address-window rejection and a WAIT timeout.
module l3_ring_arbiter
  import l3_arb_pkg::*;
#(
  parameter int                NUM_REQ = 2,
  parameter int                ADDR_W  = 64,
  parameter int                DATA_W  = 64,
  parameter logic [ADDR_W-1:0] L3_BASE = '0,
  parameter longint unsigned   L3_SIZE = L3_SIZE_DEF,
  parameter int unsigned       TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_ready,
  output logic [NUM_REQ-1:0]          rsp_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  input  logic [DATA_W-1:0]           mem_rd_data,
  input  logic                        mem_rd_done,
  input  logic                        mem_wr_done,
  output logic                        busy
);

  localparam int                IDX_W     = idx_w(NUM_REQ);
  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] SIZE_A    = ADDR_W'(L3_SIZE);
  localparam logic [CNT_W-1:0]  TCNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  last_grant, grant_q, pick_idx;
  logic              pick_any;
  logic              err_q;
  logic [CNT_W-1:0]  tcnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic [ADDR_W-1:0] sel_addr, sel_off;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_win, active, done_match, expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .any_req    (pick_any)
  );

  // Unsigned offset compare: addresses below the base wrap to huge values and fail.
  assign sel_addr   = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata  = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
  assign sel_off    = sel_addr - L3_BASE;
  assign in_win     = (sel_off < SIZE_A);
  assign done_match = we_q ? mem_wr_done : mem_rd_done;
  assign expire     = (tcnt == TCNT_LAST);
  assign active     = (state == ST_ISSUE) || (state == ST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= LAST_INIT;
      grant_q    <= '0;
      err_q      <= 1'b0;
      tcnt       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_idx;
            last_grant <= pick_idx;
            err_q      <= !in_win;
          end
        end
        ST_ISSUE: tcnt <= '0;
        ST_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (!done_match && expire) err_q <= 1'b1;
        end
        ST_RESP: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Transaction payload; outputs are gated by state, so these need no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && pick_any) begin
      we_q    <= req_we[pick_idx];
      addr_q  <= sel_off;
      wdata_q <= sel_wdata;
      rdata_q <= '0;
    end else if (state == ST_WAIT && !we_q && mem_rd_done) begin
      rdata_q <= mem_rd_data;
    end
  end

  always_comb begin
    state_nxt   = state;
    rsp_ready   = '0;
    rsp_err     = '0;
    rsp_rdata   = '0;
    mem_rd_en   = active && !we_q;
    mem_wr_en   = active && we_q;
    mem_addr    = active ? addr_q : '0;
    mem_wr_data = (active && we_q) ? wdata_q : '0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = in_win ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (done_match || expire) state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_ready[grant_q] = 1'b1;
        rsp_err[grant_q]   = err_q;
        rsp_rdata          = rdata_q;
        state_nxt          = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l3_ring_arbiter.sv
// Scoreboard bench for l3_ring_arbiter with a behavioural memory that answers
// after a programmable number of WAIT cycles.
module tb_l3_ring_arbiter;

  localparam logic [63:0] BASE = 64'h1000;
  localparam logic [63:0] SIZE = 64'd4194304;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_we = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [1:0]   rsp_ready, rsp_err;
  logic [63:0]  rsp_rdata;
  logic         mem_rd_en, mem_wr_en;
  logic [63:0]  mem_addr, mem_wr_data, mem_rd_data;
  logic         mem_rd_done = 1'b0;
  logic         mem_wr_done = 1'b0;
  logic         busy;

  l3_ring_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (64),
    .DATA_W  (64),
    .L3_BASE (BASE),
    .L3_SIZE (SIZE),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_ready   (rsp_ready),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_rd_done (mem_rd_done),
    .mem_wr_done (mem_wr_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          err;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;

  // memory model knobs
  int          mem_lat   = 1;
  bit          spurious  = 1'b0;
  bit          fixed_en  = 1'b0;
  logic [63:0] fixed_val = '0;
  bit          chk_mem   = 1'b0;
  logic [63:0] exp_mem_addr = '0;
  logic [63:0] exp_wdata = '0;
  bit          exp_we = 1'b0;
  int          en_cnt = 0;
  int          en_cycles = 0;

  function automatic logic [63:0] mem_f(input logic [63:0] off);
    return 64'hC0DE_0000_0000_0000 | {32'd0, off[31:0]};
  endfunction

  assign mem_rd_data = fixed_en ? fixed_val : mem_f(mem_addr);

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory: done for the pending op is raised in WAIT cycle mem_lat (0 = never).
  always @(negedge clk) begin
    mem_rd_done = 1'b0;
    mem_wr_done = 1'b0;
    if (mem_rd_en || mem_wr_en) begin
      en_cnt++;
      en_cycles++;
      check_eq("mem_en_excl", 64'(mem_rd_en & mem_wr_en), 64'd0);
      if (chk_mem) begin
        check_eq("mem_addr", mem_addr, exp_mem_addr);
        check_eq("mem_rd_en", 64'(mem_rd_en), 64'(!exp_we));
        if (exp_we) check_eq("mem_wr_data", mem_wr_data, exp_wdata);
      end
      if (mem_lat != 0 && en_cnt == mem_lat + 1) begin
        if (mem_wr_en) mem_wr_done = 1'b1;
        else           mem_rd_done = 1'b1;
      end else if (spurious && en_cnt == mem_lat) begin
        if (mem_wr_en) mem_rd_done = 1'b1;
        else           mem_wr_done = 1'b1;
      end
    end else begin
      en_cnt = 0;
    end
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (rsp_ready != 2'b00) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(rsp_ready), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("rsp_ready", 64'(rsp_ready), 64'd1 << mon_e.idx);
        check_eq("rsp_err", 64'(rsp_err), mon_e.err ? (64'd1 << mon_e.idx) : 64'd0);
        check_eq("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  task automatic run_req(input int idx, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata, input bit exp_err,
                         input logic [63:0] exp_rdata, input int exp_lat,
                         input int exp_en, input string tag);
    int lat;
    int en_base;
    @(negedge clk);
    sb_q.push_back('{idx: idx, err: exp_err, rdata: exp_rdata});
    exp_mem_addr = addr - BASE;
    exp_we       = we;
    exp_wdata    = wdata;
    chk_mem      = 1'b1;
    en_base      = en_cycles;
    req_we[idx]  = we;
    req_addr[idx*64 +: 64]  = addr;
    req_wdata[idx*64 +: 64] = wdata;
    req_valid[idx] = 1'b1;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_ready[idx]) begin
        req_addr[idx*64 +: 64]  = {$urandom, $urandom};
        req_wdata[idx*64 +: 64] = {$urandom, $urandom};
        req_we[idx] = ~we;
      end
    end while (!rsp_ready[idx] && lat < 300);
    req_valid[idx] = 1'b0;
    req_we[idx]    = we;
    chk_mem        = 1'b0;
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_en_cycles"}, 64'(en_cycles - en_base), 64'(exp_en));
  endtask

  task automatic run_both(input int n, input string tag);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    @(negedge clk);
    req_valid = 2'b11;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rsp_ready != 2'b00) got++;
    end
    req_valid = 2'b00;
    check_eq({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check_eq("rst_ctrl", 64'({rsp_ready, rsp_err, mem_rd_en, mem_wr_en, busy}), 64'd0);
    check_eq("rst_rdata", rsp_rdata, 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single read
    mem_lat = 1; fixed_en = 1'b1; fixed_val = 64'hDEADBEEF;
    run_req(0, 1'b0, BASE + 64'h10, 64'h0, 1'b0, 64'hDEADBEEF, 4, 2, "rd");
    fixed_en = 1'b0;

    // write with a spurious rd_done first
    mem_lat = 2; spurious = 1'b1;
    run_req(1, 1'b1, BASE + 64'h40, 64'h55, 1'b0, 64'h0, 5, 3, "wr");
    spurious = 1'b0;

    // window edges
    mem_lat = 1;
    run_req(0, 1'b0, 64'h0FFF, 64'h0, 1'b1, 64'h0, 2, 0, "below_base");
    run_req(0, 1'b0, BASE + SIZE, 64'h0, 1'b1, 64'h0, 2, 0, "at_limit");
    run_req(1, 1'b0, BASE + SIZE - 64'd1, 64'h0, 1'b0, mem_f(SIZE - 64'd1), 4, 2, "last_word");

    // contention after requester 1 was served last: expect 0,1,0,1
    req_we = 2'b00;
    req_addr  = {BASE + 64'h200, BASE + 64'h100};
    sb_q.push_back('{idx: 0, err: 1'b0, rdata: mem_f(64'h100)});
    sb_q.push_back('{idx: 1, err: 1'b0, rdata: mem_f(64'h200)});
    sb_q.push_back('{idx: 0, err: 1'b0, rdata: mem_f(64'h100)});
    sb_q.push_back('{idx: 1, err: 1'b0, rdata: mem_f(64'h200)});
    run_both(4, "contend");

    // timeout, then done landing exactly on the expiry cycle
    mem_lat = 0;
    run_req(0, 1'b0, BASE + 64'h80, 64'h0, 1'b1, 64'h0, 11, 9, "timeout");
    mem_lat = 8;
    run_req(1, 1'b0, BASE + 64'h88, 64'h0, 1'b0, mem_f(64'h88), 11, 9, "expiry_done");

    // asynchronous reset in the middle of WAIT
    mem_lat = 0;
    @(negedge clk);
    req_we = 2'b00;
    req_addr[63:0] = BASE + 64'h20;
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    check_eq("wait_busy", 64'({busy, mem_rd_en}), 64'd3);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_ctrl", 64'({rsp_ready, rsp_err, mem_rd_en, mem_wr_en, busy}), 64'd0);
    check_eq("arst_mem_addr", mem_addr, 64'd0);
    check_eq("arst_rdata", rsp_rdata, 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 1;
    req_addr = {BASE + 64'h300, BASE + 64'h30};
    sb_q.push_back('{idx: 0, err: 1'b0, rdata: mem_f(64'h30)});
    sb_q.push_back('{idx: 1, err: 1'b0, rdata: mem_f(64'h300)});
    run_both(2, "post_rst");

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l3_ring_arbiter.md
Name: l3_ring_arbiter

Overview:
- Shares one L3 memory instance between NUM_REQ supercore ring ports using round-robin arbitration, one transaction in flight.
- Supports reads and writes.
- Checks each request against the L3 address window; out-of-window requests are rejected with an error and never reach memory.
- Sits between the supercore ring ports and the mem instance inside cpu. It replaces the fixed-priority inline arbitration.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
ADDR_W, 64, address width
DATA_W, 64, data width
L3_BASE, 0, first address of the L3 window
L3_SIZE, 4194304, window size in words; valid addresses are L3_BASE <= addr < L3_BASE+L3_SIZE
TIMEOUT, 1024, max WAIT cycles before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request, level, held until rsp_ready
req_we  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
rsp_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_err  out  NUM_REQ  valid with rsp_ready; 1 = out-of-window or timeout
rsp_rdata  out  DATA_W  shared read data, valid with rsp_ready; 0 on write or error
mem_rd_en  out  1  memory read enable, level, held until mem_rd_done
mem_wr_en  out  1  memory write enable, level, held until mem_wr_done
mem_addr  out  ADDR_W  window offset (req_addr - L3_BASE)
mem_wr_data  out  DATA_W  write data
mem_rd_data  in  DATA_W  read data, valid with mem_rd_done
mem_rd_done  in  1  read complete
mem_wr_done  in  1  write complete
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): all outputs 0, state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick the first asserted index searching from last_grant+1 with wrap. Register grant, we, addr offset, wdata; set last_grant=grant.
  - In window: go to ISSUE.
  - Out of window: set err flag, go directly to RESP with no memory access.
  - No request: stay in IDLE.
- Window check: compute (addr - L3_BASE) in ADDR_W bits unsigned, accept iff the result < L3_SIZE. Wrap-around below the base therefore fails. addr = L3_BASE+L3_SIZE is rejected; addr = L3_BASE+L3_SIZE-1 is accepted.
- ISSUE: assert mem_rd_en or mem_wr_en (per we) with mem_addr and mem_wr_data. Go to WAIT; clear the timeout counter.
- WAIT: hold the enable and the mem buses stable.
  - The done matching the op (rd_done for reads, wr_done for writes) ends WAIT: drop the enable, capture mem_rd_data (reads), go to RESP.
  - A non-matching done is ignored.
  - The counter increments each cycle. At TIMEOUT with no matching done: drop the enable, set err, go to RESP.
  - A matching done in the same cycle as expiry wins (no err).
- RESP: rsp_ready[grant]=1 for exactly one cycle, rsp_err[grant] per err flag, rsp_rdata per capture. Then IDLE, clearing err.
- Requester rule: sample rsp_ready at the clock edge, then drop or replace the request at that edge. The arbiter samples fresh req_valid in the following IDLE cycle.
- Latency: minimum 4 cycles from req_valid to rsp_ready when memory returns done in the first WAIT cycle (IDLE, ISSUE, WAIT, RESP). Out-of-window latency is 2 cycles.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Changes to req_* after grant are ignored; the registered copy is used.
- At most one of mem_rd_en / mem_wr_en is high at any time.
- rsp_ready is one-hot or zero.

Decomposition:
- Package l3_arb_pkg: state encoding (ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_RESP=3), default L3_SIZE and TIMEOUT constants.
- One sub-module, rr_pick: combinational round-robin selector. Inputs: req vector, last_grant. Outputs: grant index, any_req.
- The FSM, window check and timeout counter live in l3_ring_arbiter.

Test Plan:
- Single read: req_valid=01, addr=0x10, mem returns rd_done with 0xDEADBEEF on the first WAIT cycle -> mem_rd_en high 2 cycles with mem_addr=0x10; rsp_ready=01 exactly 4 cycles after the request; rsp_rdata=0xDEADBEEF; err=0.
- Contention: req_valid=11 held after each response for 4 transactions -> grant order 0,1,0,1; never both rsp_ready bits high.
- Window edges with L3_BASE=0x1000:
  - addr 0x0FFF -> err=1, no mem enable, 2-cycle latency.
  - addr 0x1000+L3_SIZE -> err=1.
  - addr 0x1000+L3_SIZE-1 -> accepted, mem_addr=L3_SIZE-1.
- Write: req_we=1, wdata=0x55; mem asserts rd_done (spurious) then wr_done -> the spurious done is ignored; completion on wr_done; rsp_rdata=0.
- Timeout (TIMEOUT=8): memory never responds -> enable drops after 8 WAIT cycles; rsp_err=1. A second run with done arriving on the expiry cycle -> rsp_err=0.
- Reset mid-WAIT: assert rst asynchronously -> all outputs 0 immediately. After release with req_valid=11, requester 0 is granted first.
